// File: rtl/sc_tonesched_pkg.sv
// Shared types and constants for the tone scheduler: FSM encoding, note half-period table, tick default.
// Half-periods are 50 MHz clock counts per output half-cycle (equal temperament, rounded).
package sc_tonesched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int TICK_DIV_DEFAULT = 50000;

  // Code 0 is a rest; 1..12 are A4..G#5; 13..15 are A3, A5, A2.
  function automatic logic [17:0] half_lookup(input logic [3:0] note);
    case (note)
      4'd1:    return 18'd56818;
      4'd2:    return 18'd53629;
      4'd3:    return 18'd50619;
      4'd4:    return 18'd47778;
      4'd5:    return 18'd45097;
      4'd6:    return 18'd42566;
      4'd7:    return 18'd40177;
      4'd8:    return 18'd37922;
      4'd9:    return 18'd35793;
      4'd10:   return 18'd33784;
      4'd11:   return 18'd31888;
      4'd12:   return 18'd30098;
      4'd13:   return 18'd113636;
      4'd14:   return 18'd28409;
      4'd15:   return 18'd227273;
      default: return 18'd0;
    endcase
  endfunction

endpackage

// File: rtl/sc_tone_scheduler_if.sv
// Requester/scheduler bundle: level requests with note/duration in, grant pulses and tone status out.
// master = requester side (game/alarm logic), slave = the scheduler.
interface sc_tone_scheduler_if #(
  parameter int NOTE_WIDTH = 4,
  parameter int DUR_WIDTH  = 8
);
  logic                  SC_TONESCHED_reqA_In;
  logic [NOTE_WIDTH-1:0] SC_TONESCHED_noteA_InBUS;
  logic [DUR_WIDTH-1:0]  SC_TONESCHED_durA_InBUS;
  logic                  SC_TONESCHED_ackA_Out;
  logic                  SC_TONESCHED_reqB_In;
  logic [NOTE_WIDTH-1:0] SC_TONESCHED_noteB_InBUS;
  logic [DUR_WIDTH-1:0]  SC_TONESCHED_durB_InBUS;
  logic                  SC_TONESCHED_ackB_Out;
  logic                  SC_TONESCHED_abort_In;
  logic                  SC_TONESCHED_busy_Out;
  logic                  SC_TONESCHED_owner_Out;
  logic                  SC_TONESCHED_done_Out;
  logic                  SC_TONESCHED_signal_OutHigh;

  modport master (
    output SC_TONESCHED_reqA_In, SC_TONESCHED_noteA_InBUS, SC_TONESCHED_durA_InBUS,
    output SC_TONESCHED_reqB_In, SC_TONESCHED_noteB_InBUS, SC_TONESCHED_durB_InBUS,
    output SC_TONESCHED_abort_In,
    input  SC_TONESCHED_ackA_Out, SC_TONESCHED_ackB_Out, SC_TONESCHED_busy_Out,
    input  SC_TONESCHED_owner_Out, SC_TONESCHED_done_Out, SC_TONESCHED_signal_OutHigh
  );

  modport slave (
    input  SC_TONESCHED_reqA_In, SC_TONESCHED_noteA_InBUS, SC_TONESCHED_durA_InBUS,
    input  SC_TONESCHED_reqB_In, SC_TONESCHED_noteB_InBUS, SC_TONESCHED_durB_InBUS,
    input  SC_TONESCHED_abort_In,
    output SC_TONESCHED_ackA_Out, SC_TONESCHED_ackB_Out, SC_TONESCHED_busy_Out,
    output SC_TONESCHED_owner_Out, SC_TONESCHED_done_Out, SC_TONESCHED_signal_OutHigh
  );
endinterface

// File: rtl/sc_tone_divider.sv
// Square-wave generator: counts 0..half_period-1 and toggles tone at each wrap; first rise half_period cycles after clear.
// clear has priority over enable and forces tone low; no backpressure.
module sc_tone_divider #(
  parameter int DIV_WIDTH = 18
) (
  input  logic                 SC_TONESCHED_CLOCK_50,
  input  logic                 SC_TONESCHED_RESET_InLow,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 tone
);
  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge SC_TONESCHED_CLOCK_50 or negedge SC_TONESCHED_RESET_InLow) begin
    if (!SC_TONESCHED_RESET_InLow) begin
      cnt_q <= '0;
      tone  <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      tone  <= 1'b0;
    end else if (enable) begin
      if (cnt_q == half_period - 1'b1) begin
        cnt_q <= '0;
        tone  <= ~tone;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sc_tone_scheduler.sv
// Shares one tone divider between requesters A/B: grant (ack next cycle), 1-cycle LOAD, PLAY for dur*TICK_DIV cycles, done pulse.
// Requests are levels sampled only in IDLE; SC_TONESCHED_ROUNDROBIN_EN makes ties go to the previous non-owner.
module sc_tone_scheduler
  import sc_tonesched_pkg::*;
#(
  parameter int DIV_WIDTH  = 18,
  parameter int DUR_WIDTH  = 8,
  parameter int NOTE_WIDTH = 4,
  parameter int TICK_DIV   = TICK_DIV_DEFAULT
) (
  input logic                SC_TONESCHED_CLOCK_50,
  input logic                SC_TONESCHED_RESET_InLow,
  sc_tone_scheduler_if.slave tsif
);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t                state, state_nxt;
  logic [NOTE_WIDTH-1:0] note_q;
  logic [DUR_WIDTH-1:0]  dur_q;
  logic [DIV_WIDTH-1:0]  half_q;
  logic [TICK_W-1:0]     tick_q;
  logic                  owner_q, busy_q, ack_a_q, ack_b_q, done_q;
  logic                  any_req, pick_b, tick_wrap, play_fin;
  logic                  grant, ack_a_nxt, ack_b_nxt, done_nxt, div_clr, div_en;
  logic                  tone;

  assign any_req = tsif.SC_TONESCHED_reqA_In | tsif.SC_TONESCHED_reqB_In;
`ifdef SC_TONESCHED_ROUNDROBIN_EN
  assign pick_b = (tsif.SC_TONESCHED_reqA_In && tsif.SC_TONESCHED_reqB_In) ? !owner_q
                                                                           : tsif.SC_TONESCHED_reqB_In;
`else
  assign pick_b = tsif.SC_TONESCHED_reqB_In && !tsif.SC_TONESCHED_reqA_In;
`endif

  // A zero duration ends PLAY on its first edge; otherwise the last tick wrap ends it.
  assign tick_wrap = (tick_q == TICK_LAST);
  assign play_fin  = (state == PLAY) &&
                     ((dur_q == '0) || (tick_wrap && (dur_q == DUR_WIDTH'(1))));

  always_ff @(posedge SC_TONESCHED_CLOCK_50 or negedge SC_TONESCHED_RESET_InLow) begin
    if (!SC_TONESCHED_RESET_InLow) state <= IDLE;
    else                           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOAD;
      LOAD:    state_nxt = tsif.SC_TONESCHED_abort_In ? IDLE : PLAY;
      PLAY:    if (tsif.SC_TONESCHED_abort_In || play_fin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Abort outranks a coinciding final tick, so done only fires on natural completion.
  always_comb begin
    grant     = (state == IDLE) && any_req;
    ack_a_nxt = grant && !pick_b;
    ack_b_nxt = grant && pick_b;
    done_nxt  = play_fin && !tsif.SC_TONESCHED_abort_In;
    div_clr   = (state != PLAY) || (state_nxt == IDLE);
    div_en    = (state == PLAY) && (half_q != '0);
  end

  always_ff @(posedge SC_TONESCHED_CLOCK_50 or negedge SC_TONESCHED_RESET_InLow) begin
    if (!SC_TONESCHED_RESET_InLow) begin
      note_q  <= '0;
      dur_q   <= '0;
      half_q  <= '0;
      tick_q  <= '0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q  <= (state_nxt != IDLE);
      ack_a_q <= ack_a_nxt;
      ack_b_q <= ack_b_nxt;
      done_q  <= done_nxt;
      if (grant) begin
        note_q  <= pick_b ? tsif.SC_TONESCHED_noteB_InBUS : tsif.SC_TONESCHED_noteA_InBUS;
        dur_q   <= pick_b ? tsif.SC_TONESCHED_durB_InBUS  : tsif.SC_TONESCHED_durA_InBUS;
        owner_q <= pick_b;
      end
      if (state == LOAD) begin
        half_q <= DIV_WIDTH'(half_lookup(4'(note_q)));
        tick_q <= '0;
      end else if (state == PLAY) begin
        if (tick_wrap) begin
          tick_q <= '0;
          if (dur_q != '0) dur_q <= dur_q - 1'b1;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end
    end
  end

  sc_tone_divider #(.DIV_WIDTH(DIV_WIDTH)) u_divider (
    .SC_TONESCHED_CLOCK_50   (SC_TONESCHED_CLOCK_50),
    .SC_TONESCHED_RESET_InLow(SC_TONESCHED_RESET_InLow),
    .clear                   (div_clr),
    .enable                  (div_en),
    .half_period             (half_q),
    .tone                    (tone)
  );

  assign tsif.SC_TONESCHED_ackA_Out       = ack_a_q;
  assign tsif.SC_TONESCHED_ackB_Out       = ack_b_q;
  assign tsif.SC_TONESCHED_busy_Out       = busy_q;
  assign tsif.SC_TONESCHED_owner_Out      = owner_q;
  assign tsif.SC_TONESCHED_done_Out       = done_q;
  assign tsif.SC_TONESCHED_signal_OutHigh = tone;
endmodule

// File: tb/tb_sc_tone_scheduler.sv
// Bench for sc_tone_scheduler: a note-level model queues expected acks/dones and busy/tone windows;
// an independent monitor compares them against the DUT outputs each cycle.
module tb_sc_tone_scheduler;
  localparam int TICK = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_tone_scheduler_if #(.NOTE_WIDTH(4), .DUR_WIDTH(8)) tif ();

  sc_tone_scheduler #(.DIV_WIDTH(18), .DUR_WIDTH(8), .NOTE_WIDTH(4), .TICK_DIV(TICK)) dut (
    .SC_TONESCHED_CLOCK_50   (clk),
    .SC_TONESCHED_RESET_InLow(rst_n),
    .tsif                    (tif)
  );

  typedef struct { int note; int dur; int ab; } job_t;     // ab: abort edge offset from PLAY entry, -1 = none
  typedef struct { int kind; int cyc; int owner; } ev_t;   // kind 0 = ackA, 1 = ackB, 2 = done
  typedef struct { int g; int e; int x; int half; } win_t; // grant cycle, PLAY entry, exit cycle, half-period

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  bit   model_owner = 1'b0;
  ev_t  ev_q[$];
  win_t win_q[$];
  job_t ja[$];
  job_t jb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Half-period straight from the musical definition of each code.
  function automatic int ref_half(input int code);
    real f;
    if (code == 0) return 0;
    if (code <= 12)      f = 440.0 * $pow(2.0, (code - 1) / 12.0);
    else if (code == 13) f = 220.0;
    else if (code == 14) f = 880.0;
    else                 f = 110.0;
    return $rtoi(25.0e6 / f + 0.5);
  endfunction

  function automatic job_t mk_job(input int note, input int dur, input int ab);
    job_t j;
    j.note = note; j.dur = dur; j.ab = ab;
    return j;
  endfunction

  int prev_busy = 0, prev_sig = 0, prev_eb = 0, prev_es = 0;

  always @(negedge clk) begin : monitor
    int   eb, es, kind, bsy, sg;
    ev_t  e;
    if (mon_en) begin
      eb = 0; es = 0;
      while (win_q.size() > 0 && win_q[0].x + 2 < cyc) win_q.delete(0);
      foreach (win_q[i]) begin
        if (cyc >= win_q[i].g && cyc < win_q[i].x) eb = 1;
        if (win_q[i].half > 0 && cyc >= win_q[i].e && cyc < win_q[i].x)
          es = ((cyc - win_q[i].e) / win_q[i].half) % 2;
      end
      bsy = int'(tif.SC_TONESCHED_busy_Out);
      sg  = int'(tif.SC_TONESCHED_signal_OutHigh);
      if (bsy != prev_busy || eb != prev_eb) check("busy", bsy, eb);
      if (sg != prev_sig || es != prev_es)   check("signal", sg, es);
      prev_busy = bsy; prev_sig = sg; prev_eb = eb; prev_es = es;
      if (tif.SC_TONESCHED_ackA_Out || tif.SC_TONESCHED_ackB_Out || tif.SC_TONESCHED_done_Out) begin
        kind = tif.SC_TONESCHED_ackA_Out ? 0 : (tif.SC_TONESCHED_ackB_Out ? 1 : 2);
        if (ev_q.size() == 0) check("spurious_event", kind, -1);
        else begin
          e = ev_q.pop_front();
          check("event_kind", kind, e.kind);
          check("event_cycle", cyc, e.cyc);
          if (e.kind != 2) check("owner", int'(tif.SC_TONESCHED_owner_Out), e.owner);
        end
      end
    end
  end

  // Plays the jobs queued in ja/jb: all requests rise together, each requester holds req until its last grant.
  task automatic episode(input bit idle_abort);
    job_t qa[$], qb[$], js[$], j;
    int   who[$], gs[$], es[$];
    int   p0, t, g, e, xn, x;
    bit   pb;
    qa = ja; qb = jb; ja.delete(); jb.delete();
    @(posedge clk); #2;
    p0 = cyc; t = p0 + 1;
    while (qa.size() > 0 || qb.size() > 0) begin
      if (qa.size() > 0 && qb.size() > 0) begin
`ifdef SC_TONESCHED_ROUNDROBIN_EN
        pb = !model_owner;
`else
        pb = 1'b0;
`endif
      end else pb = (qa.size() == 0);
      if (pb) j = qb.pop_front();
      else    j = qa.pop_front();
      g  = t; e = g + 1;
      xn = (j.dur == 0) ? e + 1 : e + j.dur * TICK;
      if (j.ab > xn - e) j.ab = xn - e;
      x  = (j.ab >= 0) ? e + j.ab : xn;
      ev_q.push_back('{pb ? 1 : 0, g, pb ? 1 : 0});
      if (j.ab < 0) ev_q.push_back('{2, x, 0});
      win_q.push_back('{g, e, x, ref_half(j.note)});
      model_owner = pb;
      who.push_back(pb ? 1 : 0); gs.push_back(g); es.push_back(e); js.push_back(j);
      t = x + 1;
    end
    for (int c = p0; c <= t; c++) begin
      bit fa, fb, ab;
      fa = 1'b0; fb = 1'b0;
      ab = idle_abort && (c == p0);
      tif.SC_TONESCHED_reqA_In     = 1'b0;
      tif.SC_TONESCHED_reqB_In     = 1'b0;
      tif.SC_TONESCHED_noteA_InBUS = 4'($urandom_range(0, 15));
      tif.SC_TONESCHED_noteB_InBUS = 4'($urandom_range(0, 15));
      tif.SC_TONESCHED_durA_InBUS  = 8'($urandom_range(0, 255));
      tif.SC_TONESCHED_durB_InBUS  = 8'($urandom_range(0, 255));
      for (int k = 0; k < gs.size(); k++) begin
        if (who[k] == 0 && !fa && c < gs[k]) begin
          fa = 1'b1;
          tif.SC_TONESCHED_reqA_In     = 1'b1;
          tif.SC_TONESCHED_noteA_InBUS = 4'(js[k].note);
          tif.SC_TONESCHED_durA_InBUS  = 8'(js[k].dur);
        end
        if (who[k] == 1 && !fb && c < gs[k]) begin
          fb = 1'b1;
          tif.SC_TONESCHED_reqB_In     = 1'b1;
          tif.SC_TONESCHED_noteB_InBUS = 4'(js[k].note);
          tif.SC_TONESCHED_durB_InBUS  = 8'(js[k].dur);
        end
        if (js[k].ab >= 0 && c == es[k] + js[k].ab - 1) ab = 1'b1;
      end
      tif.SC_TONESCHED_abort_In = ab;
      @(posedge clk); #2;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ackA"},   int'(tif.SC_TONESCHED_ackA_Out), 0);
    check({tag, "_ackB"},   int'(tif.SC_TONESCHED_ackB_Out), 0);
    check({tag, "_busy"},   int'(tif.SC_TONESCHED_busy_Out), 0);
    check({tag, "_owner"},  int'(tif.SC_TONESCHED_owner_Out), 0);
    check({tag, "_done"},   int'(tif.SC_TONESCHED_done_Out), 0);
    check({tag, "_signal"}, int'(tif.SC_TONESCHED_signal_OutHigh), 0);
  endtask

  initial begin
    tif.SC_TONESCHED_reqA_In = 1'b0; tif.SC_TONESCHED_noteA_InBUS = '0; tif.SC_TONESCHED_durA_InBUS = '0;
    tif.SC_TONESCHED_reqB_In = 1'b0; tif.SC_TONESCHED_noteB_InBUS = '0; tif.SC_TONESCHED_durB_InBUS = '0;
    tif.SC_TONESCHED_abort_In = 1'b0;
    repeat (3) @(posedge clk); #2;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Reset asserted in the middle of a B note (note 1, dur 5).
    @(posedge clk); #2;
    tif.SC_TONESCHED_reqB_In = 1'b1; tif.SC_TONESCHED_noteB_InBUS = 4'd1; tif.SC_TONESCHED_durB_InBUS = 8'd5;
    @(posedge clk); #2;
    tif.SC_TONESCHED_reqB_In = 1'b0;
    check("pre_reset_ackB", int'(tif.SC_TONESCHED_ackB_Out), 1);
    repeat (20) @(posedge clk); #2;
    check("pre_reset_busy", int'(tif.SC_TONESCHED_busy_Out), 1);
    check("pre_reset_owner", int'(tif.SC_TONESCHED_owner_Out), 1);
    rst_n = 1'b0; #1;
    check_all_zero("mid_play_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    model_owner = 1'b0;
    mon_en = 1'b1;

    // Long note with held request: note 14 rises once, then A is re-granted for a short note 12.
    ja.push_back(mk_job(14, 143, -1)); ja.push_back(mk_job(12, 3, -1)); episode(1'b0);
    // Contention twice: fixed priority (or alternation when round-robin is built in).
    ja.push_back(mk_job(14, 1, -1)); jb.push_back(mk_job(14, 1, -1)); episode(1'b0);
    ja.push_back(mk_job(14, 1, -1)); jb.push_back(mk_job(14, 1, -1)); episode(1'b0);
    // Zero duration, rest note, mid-PLAY abort, abort on the final tick, abort while idle.
    ja.push_back(mk_job(5, 0, -1));   episode(1'b0);
    jb.push_back(mk_job(0, 3, -1));   episode(1'b0);
    ja.push_back(mk_job(1, 10, 700)); episode(1'b0);
    jb.push_back(mk_job(3, 4, 800));  episode(1'b0);
    ja.push_back(mk_job(2, 2, -1));   episode(1'b1);

    for (int r = 0; r < 25; r++) begin
      int na, nb;
      na = $urandom_range(0, 2); nb = $urandom_range(0, 2);
      if (na + nb == 0) na = 1;
      for (int k = 0; k < na; k++)
        ja.push_back(mk_job($urandom_range(0, 15), $urandom_range(0, 4),
                            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 800)) : -1));
      for (int k = 0; k < nb; k++)
        jb.push_back(mk_job($urandom_range(0, 15), $urandom_range(0, 4),
                            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 800)) : -1));
      episode($urandom_range(0, 3) == 0);
    end

    repeat (5) @(posedge clk); #2;
    check("pending_events", ev_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
